// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with data-bus request FSM and load alignment.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   in_valid/in_ready  handshake with execute; in_op/in_rd/in_alu/in_vt form the bundle
//   dreq/dresp         data-bus request (valid, addr, size, strobe, data) and response
//   wb_*               one-cycle write-back bundle to the register-file stage
package mem_stage_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_vt,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_adel,
    output logic        wb_ades
);
    localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4, OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q;
    dbus_req_t   dreq_q;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic        ld_q;
    logic        wb_valid_q, wb_we_q, wb_adel_q, wb_ades_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic        is_ld, is_st, mis;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] sdata, ld_data_d;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign is_ld = in_op >= OP_LW && in_op <= OP_LBU;
    assign is_st = in_op >= OP_SW && in_op <= OP_SB;

    always_comb begin
        size   = (in_op == OP_LW || in_op == OP_SW) ? 3'd2 :
                 (in_op == OP_LH || in_op == OP_LHU || in_op == OP_SH) ? 3'd1 : 3'd0;
        mis    = (size == 3'd2) ? (in_alu[1:0] != 2'd0) : (size == 3'd1) ? in_alu[0] : 1'b0;
        strobe = in_op == OP_SB ? 4'b0001 << in_alu[1:0] :
                 in_op == OP_SH ? (in_alu[1] ? 4'b1100 : 4'b0011) :
                 in_op == OP_SW ? 4'b1111 : 4'b0000;
        sdata  = in_op == OP_SB ? {4{in_vt[7:0]}} :
                 in_op == OP_SH ? {2{in_vt[15:0]}} :
                 in_op == OP_SW ? in_vt : 32'd0;
        // Load extraction uses the latched op/offset, since the bundle inputs may have moved on.
        ld_b      = 8'(dresp.data >> {off_q, 3'b000});
        ld_h      = off_q[1] ? dresp.data[31:16] : dresp.data[15:0];
        ld_data_d = op_q == OP_LB  ? {{24{ld_b[7]}}, ld_b} :
                    op_q == OP_LBU ? {24'd0, ld_b} :
                    op_q == OP_LH  ? {{16{ld_h[15]}}, ld_h} :
                    op_q == OP_LHU ? {16'd0, ld_h} :
                    op_q == OP_LW  ? dresp.data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            dreq_q     <= '0;
            op_q       <= '0;
            off_q      <= '0;
            ld_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_adel_q  <= 1'b0;
            wb_ades_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q    <= in_op;
                    off_q   <= in_alu[1:0];
                    ld_q    <= is_ld;
                    wb_rd_q <= in_rd;
                    if ((is_ld || is_st) && !mis) begin
                        state_q <= REQ;
                        dreq_q  <= {1'b1, in_alu, size, strobe, sdata};
                    end else begin
                        state_q    <= DONE;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= !(is_ld || is_st) && in_rd != 5'd0;
                        wb_data_q  <= (is_ld || is_st) ? 32'd0 : in_alu;
                        wb_adel_q  <= mis && is_ld;
                        wb_ades_q  <= mis && is_st;
                    end
                end
                REQ: if (dresp.addr_ok) begin
                    dreq_q.valid <= 1'b0;
                    // data_ok without addr_ok is not a completion and is dropped here.
                    if (dresp.data_ok) begin
                        state_q    <= DONE;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= ld_q && wb_rd_q != 5'd0;
                        wb_data_q  <= ld_data_d;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: if (dresp.data_ok) begin
                    state_q    <= DONE;
                    wb_valid_q <= 1'b1;
                    wb_we_q    <= ld_q && wb_rd_q != 5'd0;
                    wb_data_q  <= ld_data_d;
                end
                DONE: begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b0;
                    wb_we_q    <= 1'b0;
                    wb_adel_q  <= 1'b0;
                    wb_ades_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = state_q == IDLE;
    assign dreq     = dreq_q;
    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_adel  = wb_adel_q;
    assign wb_ades  = wb_ades_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
// Ports: none; drives clk/resetn, the execute bundle, and a scripted data-bus responder.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        cd;
        logic        adel;
        logic        ades;
    } wb_t;

    logic        clk = 1'b0, resetn = 1'b0, in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu = '0, in_vt = '0;
    logic        in_ready, wb_valid, wb_we, wb_adel, wb_ades;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    dbus_req_t   dreq;
    dbus_resp_t  dresp = '0;

    int  checks = 0, passed = 0;
    wb_t exp_q[$];
    wb_t mon_e;

    mem_stage dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_alu(in_alu), .in_vt(in_vt),
        .dreq(dreq), .dresp(dresp),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_adel(wb_adel), .wb_ades(wb_ades)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    endtask

    always @(negedge clk) begin
        if (resetn && wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_wb: got wb_valid=1 expected no bundle (rd=%0d data=0x%08h)", wb_rd, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_we", wb_we, mon_e.we);
                chk("wb_rd", wb_rd, mon_e.rd);
                if (mon_e.cd) chk("wb_data", wb_data, mon_e.data);
                chk("wb_adel", wb_adel, mon_e.adel);
                chk("wb_ades", wb_ades, mon_e.ades);
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] vt);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_alu   = alu;
        in_vt    = vt;
    endtask

    task automatic simple_op(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] alu,
                             input logic we, input logic cd, input logic [31:0] data,
                             input logic adel, input logic ades);
        wb_t e;
        chk("in_ready_idle", in_ready, 1);
        drive(op, rd, alu, 32'h5555_AAAA);
        e = '{we: we, rd: rd, data: data, cd: cd, adel: adel, ades: ades};
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        chk("wb_valid_t1", wb_valid, 1);
        chk("no_dreq_t1", dreq.valid, 0);
        @(negedge clk);
        chk("wb_valid_drop", wb_valid, 0);
        chk("no_dreq_t2", dreq.valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic mem_op(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] vt, input int a_dly, input int d_dly,
                          input logic [31:0] rdata, input logic [2:0] sz, input logic [3:0] stb,
                          input logic [31:0] sdata, input logic [31:0] exp_data);
        wb_t e;
        chk("in_ready_idle", in_ready, 1);
        drive(op, rd, addr, vt);
        e = '{we: (op < 4'd6 && rd != 5'd0), rd: rd, data: exp_data, cd: 1'b1, adel: 1'b0, ades: 1'b0};
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i <= a_dly; i++) begin
            chk("req_valid", dreq.valid, 1);
            chk("req_addr", dreq.addr, addr);
            chk("req_size", dreq.size, sz);
            chk("req_strobe", dreq.strobe, stb);
            if (op >= 4'd6) chk("req_data", dreq.data, sdata);
            chk("in_ready_busy", in_ready, 0);
            dresp = '0;
            if (i == a_dly) begin
                dresp.addr_ok = 1'b1;
                if (d_dly == 0) begin
                    dresp.data_ok = 1'b1;
                    dresp.data    = rdata;
                end
            end else if (i == 0) begin
                dresp.data_ok = 1'b1;
                dresp.data    = 32'hBAD0_BAD0;
            end
            @(negedge clk);
        end
        dresp = '0;
        for (int i = 1; i <= d_dly; i++) begin
            chk("wait_valid", dreq.valid, 0);
            chk("in_ready_busy", in_ready, 0);
            if (i == d_dly) begin
                dresp.data_ok = 1'b1;
                dresp.data    = rdata;
            end
            @(negedge clk);
        end
        dresp = '0;
        chk("wb_valid_pulse", wb_valid, 1);
        chk("in_ready_wb", in_ready, 0);
        @(negedge clk);
        chk("wb_valid_drop", wb_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dreq_valid", dreq.valid, 0);
        chk("rst_dreq_addr", dreq.addr, 0);
        chk("rst_dreq_data", dreq.data, 0);
        chk("rst_dreq_ctl", {dreq.size, dreq.strobe}, 0);
        chk("rst_wb_flags", {wb_valid, wb_we, wb_adel, wb_ades}, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        resetn = 1'b1;
        @(negedge clk);
        // NONE ops, including an undefined opcode and rd=0.
        simple_op(4'd0, 5'd8, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
        simple_op(4'd12, 5'd0, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        // Loads with simultaneous addr_ok/data_ok.
        mem_op(4'd4, 5'd5, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000, 3'd0, 4'b0000, 32'h0, 32'hFFFF_FF80);
        mem_op(4'd5, 5'd6, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000, 3'd0, 4'b0000, 32'h0, 32'h0000_0080);
        mem_op(4'd2, 5'd9, 32'h0000_0002, 32'h0, 0, 0, 32'h8001_1234, 3'd1, 4'b0000, 32'h0, 32'hFFFF_8001);
        mem_op(4'd3, 5'd9, 32'h0000_0002, 32'h0, 1, 0, 32'h8001_1234, 3'd1, 4'b0000, 32'h0, 32'h0000_8001);
        mem_op(4'd2, 5'd10, 32'h0000_0000, 32'h0, 0, 0, 32'h8001_F234, 3'd1, 4'b0000, 32'h0, 32'hFFFF_F234);
        mem_op(4'd1, 5'd0, 32'h0000_0000, 32'h0, 0, 0, 32'h0000_0055, 3'd2, 4'b0000, 32'h0, 32'h0000_0055);
        // Stores: delayed addr_ok holds the request stable.
        mem_op(4'd7, 5'd3, 32'h0000_2002, 32'hABCD_5678, 3, 0, 32'h0, 3'd1, 4'b1100, 32'h5678_5678, 32'h0);
        mem_op(4'd8, 5'd4, 32'h0000_3001, 32'h1234_5678, 0, 2, 32'h0, 3'd0, 4'b0010, 32'h7878_7878, 32'h0);
        mem_op(4'd6, 5'd4, 32'h0000_0010, 32'hCAFE_F00D, 1, 1, 32'h0, 3'd2, 4'b1111, 32'hCAFE_F00D, 32'h0);
        // Split transaction: addr_ok in the first request cycle, data_ok four cycles later.
        mem_op(4'd1, 5'd12, 32'h0000_0004, 32'h0, 0, 4, 32'hDEAD_BEEF, 3'd2, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        // Misaligned accesses never reach the bus.
        simple_op(4'd1, 5'd7, 32'h0000_0006, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        simple_op(4'd7, 5'd7, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        simple_op(4'd3, 5'd2, 32'h0000_0003, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        // Reset while waiting for data; a late data_ok must be ignored.
        chk("in_ready_idle", in_ready, 1);
        drive(4'd1, 5'd7, 32'h0000_0008, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        dresp.addr_ok = 1'b1;
        @(negedge clk);
        dresp = '0;
        chk("rst_wait_valid", dreq.valid, 0);
        chk("rst_wait_busy", in_ready, 0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_dreq", dreq.valid, 0);
        dresp.data_ok = 1'b1;
        dresp.data    = 32'h1111_2222;
        @(negedge clk);
        dresp = '0;
        chk("late_data_ok_wb", wb_valid, 0);
        chk("late_data_ok_ready", in_ready, 1);
        @(negedge clk);
        chk("late_data_ok_wb2", wb_valid, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
